// File: rtl/image_loader_pingpong.sv
// image_loader_pingpong: host fills a two-bank pixel memory over AXI4-Lite and commits each bank;
// committed banks are streamed in order as AXI4-Stream beats while the other bank is refilled.
// Optional feature macro: IMG_LOADER_TLAST_EN (adds x_tlast and a sticky image_done STATUS bit 5).
module image_loader_pingpong #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_PIXELS  = 784,
  parameter int unsigned       ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 12'hFF0,
  parameter logic [ADDR_W-1:0] COMMIT_ADDR = 12'hFF4
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              start,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] x_tdata,
  output logic              x_tvalid,
`ifdef IMG_LOADER_TLAST_EN
  output logic              x_tlast,
`endif
  input  logic              x_tready
);

  localparam int unsigned       MW       = $clog2(NUM_PIXELS);
  localparam int unsigned       WW       = ADDR_W - 2;
  localparam logic [WW-1:0]     NPIX_W   = WW'(NUM_PIXELS);
  localparam logic [MW-1:0]     LAST_IDX = MW'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {StIdle, StPrefetch, StStream} state_e;

  state_e              state_q, state_d;
  logic [1:0]          bank_ready_q, bank_ready_d;
  logic                fill_bank_q, fill_bank_d;
  logic                stream_bank_q, stream_bank_d;
  logic [MW-1:0]       r_addr_q, r_addr_d;
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                awready_q, awready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
`ifdef IMG_LOADER_TLAST_EN
  logic                done_q, done_d;
`endif

  logic [DATA_W-1:0]   mem [2][NUM_PIXELS];

  logic                aw_hs, ar_hs, x_hs, last_hs;
  logic [WW-1:0]       aw_word;
  logic                fill_free, is_pix, is_status, is_commit, pix_we, commit_ok, wr_ok;
  logic                rd_en;
  logic [MW-1:0]       rd_idx;
  logic [31:0]         status;
  logic                unused_inputs;

  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr[1:0], s_axi_wdata};

  // Handshakes and AXI-Lite write decode against the current fill bank.
  always_comb begin
    aw_hs     = awready_q & s_axi_awvalid & s_axi_wvalid;
    ar_hs     = arready_q & s_axi_arvalid;
    x_hs      = tvalid_q & x_tready;
    last_hs   = x_hs & (r_addr_q == LAST_IDX);
    aw_word   = s_axi_awaddr[ADDR_W-1:2];
    fill_free = ~bank_ready_q[fill_bank_q];
    is_pix    = aw_word < NPIX_W;
    is_status = s_axi_awaddr == STATUS_ADDR;
    is_commit = s_axi_awaddr == COMMIT_ADDR;
    pix_we    = aw_hs & is_pix & fill_free;
    commit_ok = aw_hs & is_commit & fill_free;
    wr_ok     = is_pix ? fill_free : (is_status | (is_commit & fill_free));
  end

  // Bank bookkeeping: commit marks the fill bank ready, the last beat releases the stream bank.
  always_comb begin
    bank_ready_d = bank_ready_q;
    if (commit_ok) bank_ready_d[fill_bank_q] = 1'b1;
    if (last_hs)   bank_ready_d[stream_bank_q] = 1'b0;
    // Move to the other bank as soon as ours is committed and the other one is free.
    fill_bank_d = (bank_ready_d[fill_bank_q] && !bank_ready_d[~fill_bank_q]) ? ~fill_bank_q
                                                                             : fill_bank_q;
  end

  // Stream FSM; memory is read one beat ahead so x_tdata is valid straight from the register.
  always_comb begin
    state_d       = state_q;
    r_addr_d      = r_addr_q;
    tvalid_d      = tvalid_q;
    stream_bank_d = stream_bank_q;
    rd_en         = 1'b0;
    rd_idx        = r_addr_q;
    unique case (state_q)
      StIdle: begin
        r_addr_d = '0;
        if (start && bank_ready_q[stream_bank_q]) state_d = StPrefetch;
      end
      StPrefetch: begin
        rd_en    = 1'b1;
        rd_idx   = '0;
        tvalid_d = 1'b1;
        state_d  = StStream;
      end
      StStream: begin
        if (x_hs) begin
          if (r_addr_q == LAST_IDX) begin
            tvalid_d      = 1'b0;
            stream_bank_d = ~stream_bank_q;
            r_addr_d      = '0;
            state_d       = StIdle;
          end else begin
            rd_en    = 1'b1;
            rd_idx   = r_addr_q + MW'(1);
            r_addr_d = r_addr_q + MW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    tdata_d = rd_en ? mem[stream_bank_q][rd_idx] : tdata_q;
  end

  // AXI-Lite response channels and STATUS read.
  always_comb begin
    status      = '0;
    status[4:0] = {bank_ready_q[fill_bank_q], fill_bank_q, bank_ready_q, state_q != StIdle};
`ifdef IMG_LOADER_TLAST_EN
    status[5]   = done_q;
    done_d      = done_q;
    if (ar_hs && s_axi_araddr == STATUS_ADDR) done_d = 1'b0;
    if (last_hs) done_d = 1'b1;
`endif
    awready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
    bvalid_d  = aw_hs ? 1'b1 : (s_axi_bready ? 1'b0 : bvalid_q);
    bresp_d   = aw_hs ? (wr_ok ? 2'b00 : 2'b10) : bresp_q;
    arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;
    rvalid_d  = ar_hs ? 1'b1 : (s_axi_rready ? 1'b0 : rvalid_q);
    rdata_d   = ar_hs ? ((s_axi_araddr == STATUS_ADDR) ? status : 32'h0) : rdata_q;
  end

  // Pixel memory write port (contents are not reset).
  always_ff @(posedge s_axi_aclk) begin
    if (pix_we) mem[fill_bank_q][aw_word[MW-1:0]] <= s_axi_wdata[DATA_W-1:0];
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q       <= StIdle;
      bank_ready_q  <= 2'b00;
      fill_bank_q   <= 1'b0;
      stream_bank_q <= 1'b0;
      r_addr_q      <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      awready_q     <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
`ifdef IMG_LOADER_TLAST_EN
      done_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bank_ready_q  <= bank_ready_d;
      fill_bank_q   <= fill_bank_d;
      stream_bank_q <= stream_bank_d;
      r_addr_q      <= r_addr_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      awready_q     <= awready_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
`ifdef IMG_LOADER_TLAST_EN
      done_q        <= done_d;
`endif
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign x_tvalid      = tvalid_q;
  assign x_tdata       = tdata_q;
`ifdef IMG_LOADER_TLAST_EN
  assign x_tlast       = tvalid_q & (r_addr_q == LAST_IDX);
`endif

endmodule
